// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..DBIT_MAX data bits, optional parity, 1/2 stop bits,
// 3-sample majority voting, false-start rejection, break/overrun detection and valid/ack handshake.
module uart_rx_cfg #(
    parameter int unsigned DBIT_MAX    = 9,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    input  logic                s_tick,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    input  logic                rx_ack,
    output logic                rx_done_tick,
    output logic                rx_valid,
    output logic [DBIT_MAX-1:0] dout,
    output logic                parity_err,
    output logic                frame_err,
    output logic                break_det,
    output logic                overrun
);
    localparam int unsigned   SW       = $clog2(OVERSAMPLE);
    localparam int unsigned   H        = OVERSAMPLE / 2;
    localparam logic [SW-1:0] S_V0     = SW'(H - 1);
    localparam logic [SW-1:0] S_V1     = SW'(H);
    localparam logic [SW-1:0] S_DEC    = SW'(H + 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DB_MIN   = 4'd5;
    localparam logic [3:0]    DB_MAX   = 4'(DBIT_MAX);
    localparam logic [1:0]    PAR_EVEN = 2'b01;
    localparam logic [1:0]    PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [SW-1:0]          s_q, s_d;
    logic [3:0]             n_q, n_d;
    logic [3:0]             dbits_q, dbits_d;
    logic [1:0]             par_q, par_d;
    logic                   stop2_q, stop2_d;
    logic                   stop_idx_q, stop_idx_d;
    logic                   v0_q, v0_d, v1_q, v1_d;
    logic [DBIT_MAX-1:0]    data_q, data_d;
    logic                   pbit_q, pbit_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   stop0_q, stop0_d;

    logic                   done_d, valid_d, pe_d, fe_d, bk_d, ovr_d;
    logic [DBIT_MAX-1:0]    dout_d;

    logic [3:0]             dbits_clamp_c;
    logic                   maj_c, par_en_c, exp_par_c, last_stop_c, brk_c, ferr_c, complete_c;

    assign rxs           = sync_q[SYNC_STAGES-1];
    assign dbits_clamp_c = (cfg_dbits < DB_MIN) ? DB_MIN : (cfg_dbits > DB_MAX) ? DB_MAX : cfg_dbits;
    assign maj_c         = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
    assign par_en_c      = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign exp_par_c     = (par_q == PAR_EVEN) ? ^data_q : ~^data_q;
    assign last_stop_c   = !stop2_q || stop_idx_q;
    assign ferr_c        = ferr_q | !maj_c;
    // A break is a frame with no mark anywhere: zero data, zero parity and zero stop samples.
    assign brk_c         = (data_q == '0) && (!par_en_c || !pbit_q) && !maj_c && (!stop2_q || stop0_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            s_q          <= '0;
            n_q          <= '0;
            dbits_q      <= '0;
            par_q        <= '0;
            stop2_q      <= 1'b0;
            stop_idx_q   <= 1'b0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            data_q       <= '0;
            pbit_q       <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            stop0_q      <= 1'b0;
            rx_done_tick <= 1'b0;
            rx_valid     <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], rx};
            s_q          <= s_d;
            n_q          <= n_d;
            dbits_q      <= dbits_d;
            par_q        <= par_d;
            stop2_q      <= stop2_d;
            stop_idx_q   <= stop_idx_d;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            data_q       <= data_d;
            pbit_q       <= pbit_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            stop0_q      <= stop0_d;
            rx_done_tick <= done_d;
            rx_valid     <= valid_d;
            dout         <= dout_d;
            parity_err   <= pe_d;
            frame_err    <= fe_d;
            break_det    <= bk_d;
            overrun      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        dbits_d    = dbits_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        data_d     = data_q;
        pbit_d     = pbit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop0_d    = stop0_q;
        complete_c = 1'b0;

        // Bit-time counter and vote capture run only inside a frame.
        if (s_tick && (state_q inside {START, DATA, PARITY, STOP})) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
            if (s_q == S_V0) v0_d = rxs;
            if (s_q == S_V1) v1_d = rxs;
        end

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d    = START;
                    s_d        = '0;
                    dbits_d    = dbits_clamp_c;
                    par_d      = cfg_parity;
                    stop2_d    = cfg_stop2;
                    stop_idx_d = 1'b0;
                    data_d     = '0;
                    pbit_d     = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stop0_d    = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_DEC && maj_c) begin
                        state_d = IDLE;
                    end else if (s_q == S_LAST) begin
                        state_d = DATA;
                        n_d     = '0;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_DEC) begin
                        for (int unsigned i = 0; i < DBIT_MAX; i++) begin
                            if (n_q == 4'(i)) data_d[i] = maj_c;
                        end
                    end
                    if (s_q == S_LAST) begin
                        if (n_q == dbits_q - 4'd1) begin
                            state_d    = par_en_c ? PARITY : STOP;
                            stop_idx_d = 1'b0;
                        end else begin
                            n_d = n_q + 4'd1;
                        end
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_DEC) begin
                        pbit_d = maj_c;
                        perr_d = (maj_c != exp_par_c);
                    end
                    if (s_q == S_LAST) begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_DEC) begin
                        if (last_stop_c) begin
                            complete_c = 1'b1;
                            state_d    = brk_c ? BREAK_WAIT : IDLE;
                        end else begin
                            ferr_d  = ferr_c;
                            stop0_d = !maj_c;
                        end
                    end else if (s_q == S_LAST && !last_stop_c) begin
                        state_d    = STOP;
                        stop_idx_d = 1'b1;
                    end
                end
            end
            BREAK_WAIT: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        done_d  = complete_c;
        valid_d = rx_valid;
        ovr_d   = overrun;
        dout_d  = dout;
        pe_d    = parity_err;
        fe_d    = frame_err;
        bk_d    = break_det;
        // Completion beats a coincident ack; the ack then only consumes the overrun condition.
        if (complete_c) begin
            dout_d  = data_q;
            pe_d    = perr_q;
            fe_d    = ferr_c;
            bk_d    = brk_c;
            valid_d = 1'b1;
            if (rx_valid) ovr_d = !rx_ack;
        end else if (rx_ack && rx_valid) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: frame-level reference model with a per-cycle compare process,
// directed scenarios with literal expectations, then randomized frames and acks.
module tb_uart_rx_cfg;
    localparam int OS = 16;
    localparam int H  = OS / 2;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
        int         stop_start;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, rx, s_tick, cfg_stop2, rx_ack;
    logic [3:0] cfg_dbits;
    logic [1:0] cfg_parity;
    logic       rx_done_tick, rx_valid, parity_err, frame_err, break_det, overrun;
    logic [8:0] dout;

    int   checks = 0;
    int   failures = 0;
    int   tick_cnt = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   ack_pct = 0;
    logic ack_q = 1'b0;

    exp_t exp_q[$];
    logic       m_valid = 1'b0, m_ovr = 1'b0, m_pe = 1'b0, m_fe = 1'b0, m_bk = 1'b0;
    logic [8:0] m_dout = '0;
    exp_t       cmp_e;
    int         cmp_dt;

    uart_rx_cfg #(.DBIT_MAX(9), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .rx_ack(rx_ack), .rx_done_tick(rx_done_tick), .rx_valid(rx_valid), .dout(dout),
        .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic void check_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    function automatic void check_cond(input string nm, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // s_tick: one pulse every third clock
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            s_tick = (cyc % 3 == 0);
            cyc++;
        end
    end

    always @(posedge clk) begin
        if (s_tick) tick_cnt <= tick_cnt + 1;
        ack_q <= rx_ack;
    end

    initial begin
        rx_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rx_ack = (ack_pct > 0) && ($urandom_range(0, 999) < ack_pct);
        end
    end

    // Per-cycle compare against the frame-level model
    always @(negedge clk) begin
        if (reset) begin
            if (rx_done_tick) begin
                done_cnt++;
                check_cond("pulse_expected", exp_q.size() > 0, exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    cmp_e  = exp_q.pop_front();
                    cmp_dt = tick_cnt - cmp_e.stop_start;
                    check_cond("done_time", cmp_dt >= H + 1 && cmp_dt <= H + 5, cmp_dt, H + 3);
                    m_dout = cmp_e.d;
                    m_pe   = cmp_e.pe;
                    m_fe   = cmp_e.fe;
                    m_bk   = cmp_e.bk;
                    if (m_valid) m_ovr = !ack_q;
                    m_valid = 1'b1;
                end
            end else if (ack_q && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            check_eq("dout", 32'(dout), 32'(m_dout));
            check_eq("parity_err", 32'(parity_err), 32'(m_pe));
            check_eq("frame_err", 32'(frame_err), 32'(m_fe));
            check_eq("break_det", 32'(break_det), 32'(m_bk));
            check_eq("rx_valid", 32'(rx_valid), 32'(m_valid));
            check_eq("overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic wait_tick();
        @(posedge clk);
        while (!s_tick) @(posedge clk);
    endtask

    task automatic idle(input int nb);
        rx = 1'b1;
        repeat (nb * OS) wait_tick();
        #1;
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #3 rx_ack = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Drives one frame; the expectation is derived from the bits placed on the line.
    task automatic send_frame(input logic [3:0] db, input logic [1:0] par, input logic st2,
                              input logic [8:0] data, input bit flip, input bit sb1_bad,
                              input bit sb2_bad, input bit mid_change, input bit track);
        int         nd;
        logic [8:0] d;
        logic [8:0] mask;
        logic       pen, pbit;
        bit         bits[$];
        exp_t       e;
        int         t0;
        nd   = (db < 5) ? 5 : (db > 9) ? 9 : int'(db);
        mask = 9'((1 << nd) - 1);
        d    = data & mask;
        pen  = (par == 2'b01) || (par == 2'b10);
        pbit = ((par == 2'b01) ? ^d : ~^d) ^ flip;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(!sb1_bad);
        if (st2) bits.push_back(!sb2_bad);
        cfg_dbits  = db;
        cfg_parity = par;
        cfg_stop2  = st2;
        wait_tick();
        #1;
        t0           = tick_cnt;
        e.d          = d;
        e.pe         = pen && flip;
        e.fe         = sb1_bad || (st2 && sb2_bad);
        e.bk         = (d == 9'h0) && (!pen || !pbit) && sb1_bad && (!st2 || sb2_bad);
        e.stop_start = t0 + OS * (bits.size() - 1);
        if (track) exp_q.push_back(e);
        for (int k = 0; k < bits.size(); k++) begin
            rx = bits[k];
            for (int j = 0; j < OS; j++) begin
                wait_tick();
                if (mid_change && k == 0 && j == 3) begin
                    cfg_dbits  = 4'($urandom_range(0, 15));
                    cfg_parity = 2'($urandom_range(0, 3));
                    cfg_stop2  = 1'($urandom_range(0, 1));
                end
            end
            #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        rx = 1'b1;
        reset = 1'b0;
        cfg_dbits = 4'd8;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_done", 32'(rx_done_tick), 0);
        check_eq("rst_valid", 32'(rx_valid), 0);
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_flags", {29'd0, parity_err, frame_err, break_det}, 0);
        check_eq("rst_overrun", 32'(overrun), 0);
        reset = 1'b1;
        idle(2);

        // 8N1 0xA5
        base = done_cnt;
        send_frame(4'd8, 2'b00, 1'b0, 9'h0A5, 0, 0, 0, 0, 1);
        idle(2);
        @(negedge clk);
        check_cond("t1_pulses", done_cnt - base == 1, done_cnt - base, 1);
        check_eq("t1_dout", 32'(dout), 32'h0A5);
        check_eq("t1_flags", {29'd0, parity_err, frame_err, break_det}, 0);
        check_eq("t1_valid", 32'(rx_valid), 1);
        pulse_ack();

        // 7E1 0x35, good then bad parity
        send_frame(4'd7, 2'b01, 1'b0, 9'h035, 0, 0, 0, 0, 1);
        idle(2);
        @(negedge clk);
        check_eq("t2_pe_good", 32'(parity_err), 0);
        pulse_ack();
        send_frame(4'd7, 2'b01, 1'b0, 9'h035, 1, 0, 0, 0, 1);
        idle(2);
        @(negedge clk);
        check_eq("t2_pe_bad", 32'(parity_err), 1);
        check_eq("t2_dout", 32'(dout), 32'h035);
        check_eq("t2_valid", 32'(rx_valid), 1);
        pulse_ack();

        // 9O2 0x1FF, second stop bit low
        send_frame(4'd9, 2'b10, 1'b1, 9'h1FF, 0, 0, 1, 0, 1);
        idle(3);
        @(negedge clk);
        check_eq("t3_fe", 32'(frame_err), 1);
        check_eq("t3_dout", 32'(dout), 32'h1FF);
        check_eq("t3_bk", 32'(break_det), 0);
        check_eq("t3_pe", 32'(parity_err), 0);
        pulse_ack();

        // false start: 6 ticks low
        base = done_cnt;
        cfg_dbits = 4'd8;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        wait_tick();
        #1 rx = 1'b0;
        repeat (6) wait_tick();
        #1;
        idle(3);
        check_cond("t4_glitch_pulses", done_cnt - base == 0, done_cnt - base, 0);
        send_frame(4'd8, 2'b00, 1'b0, 9'h03C, 0, 0, 0, 0, 1);
        idle(2);
        @(negedge clk);
        check_eq("t4_dout", 32'(dout), 32'h03C);
        pulse_ack();

        // overrun
        send_frame(4'd8, 2'b00, 1'b0, 9'h011, 0, 0, 0, 0, 1);
        idle(2);
        send_frame(4'd8, 2'b00, 1'b0, 9'h022, 0, 0, 0, 0, 1);
        idle(2);
        @(negedge clk);
        check_eq("t5_dout", 32'(dout), 32'h022);
        check_eq("t5_overrun", 32'(overrun), 1);
        pulse_ack();
        check_eq("t5_valid_clr", 32'(rx_valid), 0);
        check_eq("t5_overrun_clr", 32'(overrun), 0);

        // line break: 20 bit-times low
        base = done_cnt;
        send_frame(4'd8, 2'b00, 1'b0, 9'h000, 0, 1, 0, 0, 1);
        repeat (10 * OS) wait_tick();
        #1;
        @(negedge clk);
        check_cond("t6_pulses", done_cnt - base == 1, done_cnt - base, 1);
        check_eq("t6_bk", 32'(break_det), 1);
        check_eq("t6_fe", 32'(frame_err), 1);
        check_eq("t6_dout", 32'(dout), 0);
        idle(2);
        check_cond("t6_pulses_after", done_cnt - base == 1, done_cnt - base, 1);
        pulse_ack();

        // randomized frames, configs and acks
        ack_pct = 3;
        for (int f = 0; f < 30; f++) begin
            logic [8:0] rd;
            rd = ($urandom_range(0, 9) == 0) ? 9'h000 : 9'($urandom);
            send_frame(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       rd, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 1);
            idle(2 + $urandom_range(0, 1));
        end
        ack_pct = 0;
        idle(1);
        check_cond("queue_drained", exp_q.size() == 0, exp_q.size(), 0);

        // reset mid-frame
        base = done_cnt;
        fork
            send_frame(4'd8, 2'b00, 1'b0, 9'h0F0, 0, 0, 0, 0, 0);
            begin
                repeat (60) wait_tick();
                #2 reset = 1'b0;
                m_valid = 1'b0;
                m_ovr = 1'b0;
                m_dout = '0;
                m_pe = 1'b0;
                m_fe = 1'b0;
                m_bk = 1'b0;
                #1;
                check_eq("mid_rst_done", 32'(rx_done_tick), 0);
                check_eq("mid_rst_valid", 32'(rx_valid), 0);
                check_eq("mid_rst_dout", 32'(dout), 0);
                check_eq("mid_rst_flags", {28'd0, parity_err, frame_err, break_det, overrun}, 0);
            end
        join
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(2);
        check_cond("mid_rst_no_pulse", done_cnt - base == 0, done_cnt - base, 0);
        send_frame(4'd8, 2'b00, 1'b0, 9'h05A, 0, 0, 0, 0, 1);
        idle(2);
        @(negedge clk);
        check_eq("post_rst_dout", 32'(dout), 32'h05A);
        check_eq("post_rst_valid", 32'(rx_valid), 1);
        check_cond("final_queue", exp_q.size() == 0, exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
